// File: rtl/mux_sel_sequencer_if.sv
// Handshake/bus bundle between the 8:1 mux scanner and its environment.
// The slave side is the scanner; the master side drives start, mux_y and ser_ready.
interface mux_sel_sequencer_if;
  logic       start;
  logic [2:0] sel;
  logic       mux_y;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_ready;
  logic       busy;
  logic [7:0] cap_data;
  logic       cap_valid;
  logic       frame_done;

  modport slave (
    input  start, mux_y, ser_ready,
    output sel, ser_data, ser_valid, busy, cap_data, cap_valid, frame_done
  );

  modport master (
    output start, mux_y, ser_ready,
    input  sel, ser_data, ser_valid, busy, cap_data, cap_valid, frame_done
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Scans an 8:1 mux through all select positions, streams each bit out with
// valid/ready, and assembles the eight bits into a captured byte.
module mux_sel_sequencer #(
  parameter bit MSB_FIRST    = 1'b0,
  parameter bit AUTO_RESTART = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  mux_sel_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST  = MSB_FIRST ? 3'd0 : 3'd7;

  logic [1:0] r_state;
  logic [2:0] r_sel;
  logic [7:0] r_shift;
  logic [7:0] r_cap;
  logic       r_cap_valid;
  logic       r_busy;
  logic       w_xfer;
  logic [7:0] w_assembled;

  assign w_xfer = (r_state == S_SHIFT) && bus.ser_ready;

  // Byte as it will look once the bit currently on the mux is taken.
  always_comb begin
    w_assembled        = r_shift;
    w_assembled[r_sel] = bus.mux_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= FIRST;
      r_shift     <= 8'h00;
      r_cap       <= 8'h00;
      r_cap_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sel <= FIRST;
          if (bus.start) begin
            r_state <= S_SHIFT;
            r_busy  <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_xfer) begin
            r_shift <= w_assembled;
            if (r_sel == LAST) begin
              r_state     <= S_DONE;
              r_sel       <= FIRST;
              r_cap       <= w_assembled;
              r_cap_valid <= 1'b1;
            end else begin
              r_sel <= MSB_FIRST ? r_sel - 3'd1 : r_sel + 3'd1;
            end
          end
        end
        S_DONE: begin
          r_cap_valid <= 1'b0;
          if (AUTO_RESTART && bus.start) begin
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_sel       <= FIRST;
          r_cap_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = r_sel;
  assign bus.ser_data   = bus.mux_y;
  assign bus.ser_valid  = (r_state == S_SHIFT);
  assign bus.busy       = r_busy;
  assign bus.cap_data   = r_cap;
  assign bus.cap_valid  = r_cap_valid;
  assign bus.frame_done = r_cap_valid;
endmodule
